// File: rtl/ring_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ring_pkg
//  Brief   : Shared constants and {payload,dest} field helpers for the ring.
//  Rev     : 1.0  initial release
// ============================================================================
package ring_pkg;

    localparam int c_DEF_PROC_BITS = 4;
    localparam int c_DEF_DATA_SIZE = 32;
    localparam int c_MAX_PROC_BITS = 16;
    localparam int c_MAX_DATA_SIZE = 64;
    localparam int c_MAX_MSG_W     = c_MAX_PROC_BITS + c_MAX_DATA_SIZE;

    function automatic int msg_width(input int proc_bits, input int data_size);
        return proc_bits + data_size;
    endfunction

    // Helpers work on a maximum-width container; callers size-cast the result.
    function automatic logic [c_MAX_PROC_BITS-1:0] dest_of(
        input logic [c_MAX_MSG_W-1:0] msg,
        input int                     proc_bits
    );
        logic [c_MAX_MSG_W-1:0] mask;
        mask = (c_MAX_MSG_W'(1) << proc_bits) - c_MAX_MSG_W'(1);
        return c_MAX_PROC_BITS'(msg & mask);
    endfunction

    function automatic logic [c_MAX_DATA_SIZE-1:0] payload_of(
        input logic [c_MAX_MSG_W-1:0] msg,
        input int                     proc_bits
    );
        return c_MAX_DATA_SIZE'(msg >> proc_bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_hop_node_if.sv
`default_nettype none
// ============================================================================
//  Module  : ring_hop_node_if
//  Brief   : Ring-in, inject, ring-out and eject channels of one ring hop.
//  Rev     : 1.0  initial release
// ============================================================================
interface ring_hop_node_if
    import ring_pkg::*;
#(
    parameter int unsigned PROC_BITS = c_DEF_PROC_BITS,
    parameter int unsigned DATA_SIZE = c_DEF_DATA_SIZE
);
    localparam int unsigned c_MSG_W = PROC_BITS + DATA_SIZE;

    logic [c_MSG_W-1:0]   ring_msg_in;
    logic                 ring_valid_in;
    logic                 ring_ready_out;
    logic [c_MSG_W-1:0]   inj_msg_in;
    logic                 inj_valid_in;
    logic                 inj_ready_out;
    logic [c_MSG_W-1:0]   ring_msg_out;
    logic                 ring_valid_out;
    logic                 ring_ready_in;
    logic [DATA_SIZE-1:0] eject_data_out;
    logic                 eject_valid_out;

    modport slave (
        input  ring_msg_in, ring_valid_in, inj_msg_in, inj_valid_in, ring_ready_in,
        output ring_ready_out, inj_ready_out, ring_msg_out, ring_valid_out,
               eject_data_out, eject_valid_out
    );

    modport master (
        output ring_msg_in, ring_valid_in, inj_msg_in, inj_valid_in, ring_ready_in,
        input  ring_ready_out, inj_ready_out, ring_msg_out, ring_valid_out,
               eject_data_out, eject_valid_out
    );

endinterface
`default_nettype wire

// File: rtl/ring_inj_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : ring_inj_fifo
//  Brief   : Synchronous power-of-two FIFO holding locally injected messages.
//  Rev     : 1.0  initial release
// ============================================================================
module ring_inj_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 36
) (
    input  wire logic                     clk_in,
    input  wire logic                     rst_in,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_wr_data,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_rd_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // A push into a full FIFO is refused even if a pop happens alongside it.
    assign w_push = i_push && (r_count != c_FULL);
    assign w_pop  = i_pop  && (r_count != '0);

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/ring_hop_node.sv
`default_nettype none
// ============================================================================
//  Module  : ring_hop_node
//  Brief   : One hop of the unidirectional ring: forward, inject, eject.
//            Define RING_HOP_STATS_EN to add forward/inject/eject/stall counters.
//  Rev     : 1.0  initial release
// ============================================================================
module ring_hop_node
    import ring_pkg::*;
#(
    parameter int unsigned           PROC_BITS    = c_DEF_PROC_BITS,
    parameter int unsigned           DATA_SIZE    = c_DEF_DATA_SIZE,
    parameter logic [PROC_BITS-1:0]  PROC_ID      = '0,
    parameter int unsigned           INJ_DEPTH    = 4,
    parameter int unsigned           STARVE_LIMIT = 8
) (
    input  wire logic        clk_in,
    input  wire logic        rst_in,
    ring_hop_node_if.slave   bus
`ifdef RING_HOP_STATS_EN
    ,
    output logic [31:0]      stat_fwd_out,
    output logic [31:0]      stat_inj_out,
    output logic [31:0]      stat_ej_out,
    output logic [31:0]      stat_stall_out
`endif
);
    localparam int unsigned c_MSG_W = msg_width(int'(PROC_BITS), int'(DATA_SIZE));
    localparam int unsigned c_CNT_W = $clog2(INJ_DEPTH) + 1;
    localparam int unsigned c_SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);

    logic [c_MSG_W-1:0]   w_head_msg;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_CNT_W-1:0]   w_fifo_count;
    logic                 w_unused_count;

    logic [PROC_BITS-1:0] w_ring_dest;
    logic [DATA_SIZE-1:0] w_ring_payload;
    logic [PROC_BITS-1:0] w_head_dest;
    logic [DATA_SIZE-1:0] w_head_payload;

    logic                 w_slot_free;
    logic                 w_ring_ej;
    logic                 w_ring_fwd_req;
    logic                 w_force_inj;
    logic                 w_head_fwd;
    logic                 w_head_loop;
    logic                 w_fwd_go;
    logic                 w_inj_go;
    logic                 w_loop_go;
    logic                 w_pop;

    logic [c_MSG_W-1:0]   r_ring_msg_out;
    logic                 r_ring_valid_out;
    logic [DATA_SIZE-1:0] r_eject_data;
    logic                 r_eject_valid;
    logic [c_SW-1:0]      r_starve_cnt;

    ring_inj_fifo #(
        .DEPTH (INJ_DEPTH),
        .WIDTH (c_MSG_W)
    ) u_inj_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .i_push    (bus.inj_valid_in),
        .i_wr_data (bus.inj_msg_in),
        .i_pop     (w_pop),
        .o_rd_data (w_head_msg),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign w_unused_count = ^w_fifo_count;

    assign w_ring_dest    = PROC_BITS'(dest_of(c_MAX_MSG_W'(bus.ring_msg_in), int'(PROC_BITS)));
    assign w_ring_payload = DATA_SIZE'(payload_of(c_MAX_MSG_W'(bus.ring_msg_in), int'(PROC_BITS)));
    assign w_head_dest    = PROC_BITS'(dest_of(c_MAX_MSG_W'(w_head_msg), int'(PROC_BITS)));
    assign w_head_payload = DATA_SIZE'(payload_of(c_MAX_MSG_W'(w_head_msg), int'(PROC_BITS)));

    assign w_slot_free    = !r_ring_valid_out || bus.ring_ready_in;
    assign w_ring_ej      = bus.ring_valid_in && (w_ring_dest == PROC_ID);
    assign w_ring_fwd_req = bus.ring_valid_in && (w_ring_dest != PROC_ID);
    assign w_force_inj    = (r_starve_cnt == c_STARVE_MAX);
    assign w_head_fwd     = !w_fifo_empty && (w_head_dest != PROC_ID);
    assign w_head_loop    = !w_fifo_empty && (w_head_dest == PROC_ID);

    // Ring traffic normally wins the out slot so the ring can never deadlock;
    // a starved head eventually takes one slot by force.
    assign w_fwd_go  = w_ring_fwd_req && w_slot_free && !w_force_inj;
    assign w_inj_go  = w_head_fwd && w_slot_free && (!w_ring_fwd_req || w_force_inj);
    assign w_loop_go = w_head_loop && !w_ring_ej;
    assign w_pop     = w_inj_go || w_loop_go;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_ring_valid_out <= 1'b0;
            r_ring_msg_out   <= '0;
            r_eject_valid    <= 1'b0;
            r_eject_data     <= '0;
            r_starve_cnt     <= '0;
        end else begin
            if (w_slot_free) begin
                if (w_fwd_go) begin
                    r_ring_valid_out <= 1'b1;
                    r_ring_msg_out   <= bus.ring_msg_in;
                end else if (w_inj_go) begin
                    r_ring_valid_out <= 1'b1;
                    r_ring_msg_out   <= w_head_msg;
                end else begin
                    r_ring_valid_out <= 1'b0;
                end
            end

            // Ring eject always takes the eject register; loopback retries later.
            r_eject_valid <= w_ring_ej || w_loop_go;
            if (w_ring_ej) begin
                r_eject_data <= w_ring_payload;
            end else if (w_loop_go) begin
                r_eject_data <= w_head_payload;
            end

            if (w_inj_go) begin
                r_starve_cnt <= '0;
            end else if (w_head_fwd && w_slot_free && w_ring_fwd_req && !w_force_inj) begin
                r_starve_cnt <= r_starve_cnt + c_SW'(1);
            end
        end
    end

    assign bus.ring_ready_out  = (w_ring_dest == PROC_ID) || (w_slot_free && !w_force_inj);
    assign bus.inj_ready_out   = !w_fifo_full;
    assign bus.ring_msg_out    = r_ring_msg_out;
    assign bus.ring_valid_out  = r_ring_valid_out;
    assign bus.eject_data_out  = r_eject_data;
    assign bus.eject_valid_out = r_eject_valid;

`ifdef RING_HOP_STATS_EN
    logic [31:0] r_stat_fwd;
    logic [31:0] r_stat_inj;
    logic [31:0] r_stat_ej;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_stat_fwd   <= '0;
            r_stat_inj   <= '0;
            r_stat_ej    <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_fwd_go) begin
                r_stat_fwd <= r_stat_fwd + 32'd1;
            end
            if (w_inj_go) begin
                r_stat_inj <= r_stat_inj + 32'd1;
            end
            if (w_ring_ej || w_loop_go) begin
                r_stat_ej <= r_stat_ej + 32'd1;
            end
            if (r_ring_valid_out && !bus.ring_ready_in) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_fwd_out   = r_stat_fwd;
    assign stat_inj_out   = r_stat_inj;
    assign stat_ej_out    = r_stat_ej;
    assign stat_stall_out = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ring_hop_node.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ring_hop_node
//  Brief   : Directed and randomized bench for ring_hop_node with a queue model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_ring_hop_node;

    localparam int         c_PB    = 4;
    localparam int         c_DS    = 32;
    localparam logic [3:0] c_ID    = 4'h2;
    localparam int         c_DEPTH = 4;
    localparam int         c_LIMIT = 4;

    logic clk;
    logic rst;

    ring_hop_node_if #(.PROC_BITS(c_PB), .DATA_SIZE(c_DS)) bus ();

    ring_hop_node #(
        .PROC_BITS    (c_PB),
        .DATA_SIZE    (c_DS),
        .PROC_ID      (c_ID),
        .INJ_DEPTH    (c_DEPTH),
        .STARVE_LIMIT (c_LIMIT)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: FIFO as a queue, one output slot, one eject register.
    logic [35:0] m_q[$];
    logic        m_vout;
    logic [35:0] m_msg;
    logic        m_ev;
    logic [31:0] m_edata;
    int          m_starve;
    logic        last_rr;
    int          n_acc;

    task automatic cyc(input bit rv, input logic [35:0] rm, input bit iv,
                       input logic [35:0] im, input bit rin, input bit rs);
        bit          free, ej, fwdreq, frc, hfwd, hloop, fwd_go, inj, lp, push_ok;
        logic [35:0] hd;
        @(negedge clk);
        rst               = rs;
        bus.ring_valid_in = rv;
        bus.ring_msg_in   = rm;
        bus.inj_valid_in  = iv;
        bus.inj_msg_in    = im;
        bus.ring_ready_in = rin;
        #1;
        last_rr = bus.ring_ready_out;
        if (iv && bus.inj_ready_out) n_acc++;
        if (rs) begin
            m_q.delete();
            m_vout = 0; m_msg = '0; m_ev = 0; m_edata = '0; m_starve = 0;
        end else begin
            free   = !m_vout || rin;
            ej     = rv && (rm[3:0] == c_ID);
            fwdreq = rv && !ej;
            frc    = (m_starve == c_LIMIT);
            hd     = (m_q.size() > 0) ? m_q[0] : '0;
            hfwd   = (m_q.size() > 0) && (hd[3:0] != c_ID);
            hloop  = (m_q.size() > 0) && (hd[3:0] == c_ID);
            fwd_go = fwdreq && free && !frc;
            inj    = hfwd && free && (!fwdreq || frc);
            lp     = hloop && !ej;
            push_ok = iv && (m_q.size() < c_DEPTH);
            if (rv) chk("ring_ready", bus.ring_ready_out, ej || (free && !frc));
            chk("inj_ready", bus.inj_ready_out, m_q.size() < c_DEPTH);
            if (inj) m_starve = 0;
            else if (hfwd && free && fwdreq && m_starve < c_LIMIT) m_starve++;
            if (free) begin
                if (fwd_go)   begin m_vout = 1; m_msg = rm; end
                else if (inj) begin m_vout = 1; m_msg = hd; end
                else          m_vout = 0;
            end
            m_ev = ej || lp;
            if (ej)      m_edata = rm[35:4];
            else if (lp) m_edata = hd[35:4];
            if (inj || lp) void'(m_q.pop_front());
            if (push_ok) m_q.push_back(im);
        end
        @(posedge clk);
        #1;
        chk("ring_valid", bus.ring_valid_out, m_vout);
        chk("ring_msg", bus.ring_msg_out, m_msg);
        chk("eject_valid", bus.eject_valid_out, m_ev);
        chk("eject_data", bus.eject_data_out, m_edata);
    endtask

    task automatic idle(input bit rin);
        cyc(0, '0, 0, '0, rin, 0);
    endtask

    initial begin
        int first_block;
        logic [3:0] d;
        rst = 1'b1;
        bus.ring_valid_in = 0; bus.ring_msg_in = '0;
        bus.inj_valid_in = 0;  bus.inj_msg_in = '0;
        bus.ring_ready_in = 1;

        // Reset state
        cyc(0, '0, 0, '0, 1, 1);
        chk("rst_ring_valid", bus.ring_valid_out, 0);
        chk("rst_eject_valid", bus.eject_valid_out, 0);
        chk("rst_ring_msg", bus.ring_msg_out, 0);
        chk("rst_eject_data", bus.eject_data_out, 0);

        // Eject
        cyc(1, {32'hDEADBEEF, 4'h2}, 0, '0, 1, 0);
        chk("ej_valid", bus.eject_valid_out, 1);
        chk("ej_data", bus.eject_data_out, 32'hDEADBEEF);
        chk("ej_no_fwd", bus.ring_valid_out, 0);

        // Forward and backpressure
        cyc(1, {32'h12345678, 4'h5}, 0, '0, 1, 0);
        chk("fwd_msg", bus.ring_msg_out, {32'h12345678, 4'h5});
        chk("fwd_valid", bus.ring_valid_out, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, {32'hCAFE0000 + i, 4'h5}, 0, '0, 0, 0);
            chk("bp_ready", last_rr, 0);
            chk("bp_hold", bus.ring_msg_out, {32'h12345678, 4'h5});
        end
        cyc(1, {32'hCAFE0000, 4'h5}, 0, '0, 1, 0);
        chk("bp_release", bus.ring_msg_out, {32'hCAFE0000, 4'h5});
        idle(1);

        // Starvation
        cyc(0, '0, 0, '0, 1, 1);
        first_block = -1;
        for (int i = 0; i < 8; i++) begin
            cyc(1, {32'h1000 + i, 4'h5}, i == 0, {32'hA5A5A5A5, 4'h7}, 1, 0);
            if (!last_rr && first_block < 0) begin
                first_block = i;
                chk("starve_msg", bus.ring_msg_out, {32'hA5A5A5A5, 4'h7});
            end
        end
        chk("starve_cycle", first_block, 5);
        idle(1);

        // Full FIFO plus occupied slot
        cyc(0, '0, 0, '0, 1, 1);
        n_acc = 0;
        for (int i = 0; i < 6; i++) cyc(0, '0, 1, {32'h5000 + i, 4'h9}, 0, 0);
        chk("full_accepted", n_acc, 5);
        chk("full_inj_ready", bus.inj_ready_out, 0);
        for (int i = 0; i < 6; i++) idle(1);

        // Loopback collides with ring eject
        cyc(0, '0, 1, {32'h0BADF00D, 4'h2}, 1, 0);
        cyc(1, {32'h11112222, 4'h2}, 0, '0, 1, 0);
        chk("lb_ring_first", bus.eject_data_out, 32'h11112222);
        idle(1);
        chk("lb_second_valid", bus.eject_valid_out, 1);
        chk("lb_second_data", bus.eject_data_out, 32'h0BADF00D);
        idle(1);

        // Reset mid-stream
        for (int i = 0; i < 4; i++) cyc(1, {32'h7700 + i, 4'h5}, 1, {32'h8800 + i, 4'h6}, 0, 0);
        cyc(1, {32'h7777, 4'h2}, 1, {32'h8888, 4'h6}, 0, 1);
        chk("mid_rst_ring_valid", bus.ring_valid_out, 0);
        chk("mid_rst_eject_valid", bus.eject_valid_out, 0);
        chk("mid_rst_inj_ready", bus.inj_ready_out, 1);
        for (int i = 0; i < 3; i++) idle(1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            d = ($urandom_range(0, 3) == 0) ? c_ID : 4'($urandom);
            cyc($urandom_range(0, 3) != 0, {32'($urandom), d},
                $urandom_range(0, 1) == 1, {32'($urandom), 4'($urandom)},
                $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
